// File: rtl/cp0_unit.sv
`default_nettype none
// =============================================================================
//  cp0_unit : coprocessor-0 with STATUS/CAUSE/EPC/EHBR and one-level interrupt
//  Revision : 1.0
// =============================================================================
module cp0_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  cp_oper,
  input  logic        ir_en,
  input  logic        ir_in,
  input  logic [4:0]  addr_r,
  output logic [31:0] data_r,
  input  logic [4:0]  addr_w,
  input  logic [31:0] data_w,
  input  logic [31:0] ret_addr,
  output logic        jump_en,
  output logic [31:0] jump_addr,
  output logic        in_service
);

  localparam logic [1:0] OP_MFC0 = 2'd1;
  localparam logic [1:0] OP_MTC0 = 2'd2;
  localparam logic [1:0] OP_ERET = 2'd3;

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;
  localparam logic [4:0] REG_EHBR   = 5'd15;

  localparam logic [31:0] EHBR_RESET = 32'h0000_0004;

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_SERVICE = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        sync0_q, sync1_q, prev_q;
  logic        ie_q, ie_d;
  logic        pending_q, pending_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] ehbr_q, ehbr_d;

  logic w_irq_edge;
  logic w_take;
  logic w_eret;
  logic w_mtc0;

  assign w_irq_edge = sync1_q & ~prev_q;
  assign w_mtc0     = (cp_oper == OP_MTC0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sync0_q   <= 1'b0;
      sync1_q   <= 1'b0;
      prev_q    <= 1'b0;
      ie_q      <= 1'b0;
      pending_q <= 1'b0;
      epc_q     <= 32'h0;
      ehbr_q    <= EHBR_RESET;
    end else begin
      state_q   <= state_d;
      sync0_q   <= ir_in;
      sync1_q   <= sync0_q;
      prev_q    <= sync1_q;
      ie_q      <= ie_d;
      pending_q <= pending_d;
      epc_q     <= epc_d;
      ehbr_q    <= ehbr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ie_d      = ie_q;
    pending_d = pending_q;
    epc_d     = epc_q;
    ehbr_d    = ehbr_q;
    w_take    = 1'b0;
    w_eret    = 1'b0;

    case (state_q)
      S_IDLE: begin
        w_take = pending_q & ie_q & ir_en & (cp_oper != OP_ERET);
        if (w_take) state_d = S_SERVICE;
      end
      S_SERVICE: begin
        w_eret = (cp_oper == OP_ERET);
        if (w_eret) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (w_mtc0 && addr_w == REG_STATUS) ie_d   = data_w[0];
    if (w_mtc0 && addr_w == REG_EHBR)   ehbr_d = data_w;
    // The hardware EPC capture outranks a software write in the same cycle.
    if (w_take)                         epc_d  = ret_addr;
    else if (w_mtc0 && addr_w == REG_EPC) epc_d = data_w;

    // A fresh edge in the entry cycle must not be lost to the clear.
    if (w_irq_edge)  pending_d = 1'b1;
    else if (w_take) pending_d = 1'b0;
  end

  always_comb begin
    jump_en   = 1'b0;
    jump_addr = 32'h0;
    data_r    = 32'h0;
    if (!rst) begin
      if (w_take) begin
        jump_en   = 1'b1;
        jump_addr = ehbr_q;
      end else if (w_eret) begin
        jump_en   = 1'b1;
        jump_addr = epc_q;
      end
      if (cp_oper == OP_MFC0) begin
        case (addr_r)
          REG_STATUS: data_r = {31'h0, ie_q};
          REG_CAUSE:  data_r = {31'h0, pending_q};
          REG_EPC:    data_r = epc_q;
          REG_EHBR:   data_r = ehbr_q;
          default:    data_r = 32'h0;
        endcase
      end
    end
  end

  assign in_service = (state_q == S_SERVICE) & ~rst;

endmodule
`default_nettype wire
